// File: rtl/mc_ctrl_pkg.sv
// Purpose: shared opcodes, FSM state encodings and control-word layout for the multicycle controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mc_ctrl_pkg;

  localparam int ST_W = 4;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_ADI = 4'b0001;
  localparam logic [3:0] OP_NDU = 4'b0010;
  localparam logic [3:0] OP_LW  = 4'b0100;
  localparam logic [3:0] OP_SW  = 4'b0101;
  localparam logic [3:0] OP_BEQ = 4'b1100;
  localparam logic [3:0] OP_JMP = 4'b1001;

  // R-type condition field; 2'b11 behaves like unconditional
  localparam logic [1:0] CZ_ZSET = 2'b01;
  localparam logic [1:0] CZ_CSET = 2'b10;

  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_NAND = 3'b100;

  localparam logic [1:0] SRCB_REGB = 2'b00;
  localparam logic [1:0] SRCB_ONE  = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [ST_W-1:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTEX   = 4'd6,
    S_RTWB   = 4'd7,
    S_ADIEX  = 4'd8,
    S_ADIWB  = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  typedef struct packed {
    logic       pcen;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       alusrca;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
  } ctrl_t;

  // True when a conditional R-type must be dropped (its flag is clear)
  function automatic logic cond_skip(input logic [1:0] cz, input logic c, input logic z);
    return ((cz == CZ_CSET) && !c) || ((cz == CZ_ZSET) && !z);
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Purpose: controller <-> datapath bundle (IR fields and ALU status in, enables/selects out).
// Latency: n/a (wires only); mem_ready exists only when MC_MEM_WAIT_EN is defined.
// Backpressure: mem_ready (optional) stalls the memory-facing states.
interface multicycle_controller_if;
  logic [3:0] op;
  logic [1:0] cz;
  logic       zero;
  logic       carry;
`ifdef MC_MEM_WAIT_EN
  logic       mem_ready;
`endif
  logic       pcen;
  logic       memwrite;
  logic       irwrite;
  logic       regwrite;
  logic       alusrca;
  logic       iord;
  logic       memtoreg;
  logic       regdst;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [2:0] alucontrol;

  modport master (
    input  op, cz, zero, carry,
`ifdef MC_MEM_WAIT_EN
    input  mem_ready,
`endif
    output pcen, memwrite, irwrite, regwrite, alusrca, iord,
    output memtoreg, regdst, alusrcb, pcsrc, alucontrol
  );

  modport slave (
    output op, cz, zero, carry,
`ifdef MC_MEM_WAIT_EN
    output mem_ready,
`endif
    input  pcen, memwrite, irwrite, regwrite, alusrca, iord,
    input  memtoreg, regdst, alusrcb, pcsrc, alucontrol
  );
endinterface

// File: rtl/mc_out_decode.sv
// Purpose: combinational state(+op) -> control word; pcen also folds in ALU zero for branches.
// Latency: 0 cycles (pure combinational).
// Backpressure: with MC_MEM_WAIT_EN, FETCH withholds pcen/irwrite until mem_ready.
module mc_out_decode
  import mc_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [3:0] op,
  input  logic       zero,
`ifdef MC_MEM_WAIT_EN
  input  logic       mem_ready,
`endif
  output ctrl_t      ctrl
);

  logic pcwrite;
  logic branch;

  // Moore control word per state; only pcen looks at the live zero flag
  always_comb begin
    ctrl    = '0;
    pcwrite = 1'b0;
    branch  = 1'b0;
    case (state)
      S_FETCH: begin
        ctrl.irwrite    = 1'b1;
        ctrl.alusrcb    = SRCB_ONE;
        ctrl.alucontrol = ALU_ADD;
        ctrl.pcsrc      = PCSRC_ALU;
        pcwrite         = 1'b1;
`ifdef MC_MEM_WAIT_EN
        ctrl.irwrite    = mem_ready;
        pcwrite         = mem_ready;
`endif
      end
      S_DECODE: begin
        ctrl.alusrcb    = SRCB_BOFF;
        ctrl.alucontrol = ALU_ADD;
      end
      S_MEMADR, S_ADIEX: begin
        ctrl.alusrca    = 1'b1;
        ctrl.alusrcb    = SRCB_IMM;
        ctrl.alucontrol = ALU_ADD;
      end
      S_MEMRD: ctrl.iord = 1'b1;
      S_MEMWB: begin
        ctrl.memtoreg = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      S_MEMWR: begin
        ctrl.iord     = 1'b1;
        ctrl.memwrite = 1'b1;
      end
      S_RTEX: begin
        ctrl.alusrca    = 1'b1;
        ctrl.alusrcb    = SRCB_REGB;
        ctrl.alucontrol = (op == OP_NDU) ? ALU_NAND : ALU_ADD;
      end
      S_RTWB: begin
        ctrl.regdst   = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      S_ADIWB: ctrl.regwrite = 1'b1;
      S_BRANCH: begin
        ctrl.alusrca    = 1'b1;
        ctrl.alusrcb    = SRCB_REGB;
        ctrl.alucontrol = ALU_SUB;
        ctrl.pcsrc      = PCSRC_ALUOUT;
        branch          = 1'b1;
      end
      S_JUMP: begin
        ctrl.pcsrc = PCSRC_JUMP;
        pcwrite    = 1'b1;
      end
      default: ;
    endcase
    ctrl.pcen = pcwrite | (branch & zero);
  end

endmodule

// File: rtl/multicycle_controller.sv
// Purpose: main FSM + C/Z flags for the 16-bit multicycle core (optional MC_MEM_WAIT_EN).
// Latency: ADD/NDU/ADI/SW 4, LW 5, BEQ/JMP 3, skipped/illegal 2 cycles.
// Backpressure: with MC_MEM_WAIT_EN, FETCH/MEMRD/MEMWR hold until mem_ready; else none.
module multicycle_controller
  import mc_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  multicycle_controller_if.master bus
);

  logic [STATE_W-1:0] state_q;
  state_t             cur;
  state_t             nxt;
  logic               c_flag;
  logic               z_flag;
  logic               hold;
  ctrl_t              ctrl;
  ctrl_t              ctrl_out;

  assign cur = state_t'(state_q[ST_W-1:0]);

`ifdef MC_MEM_WAIT_EN
  assign hold = !bus.mem_ready;
`else
  assign hold = 1'b0;
`endif

  // State register; reset aborts any instruction in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= STATE_W'(S_FETCH);
    else        state_q <= STATE_W'(nxt);
  end

  // Next-state: decode dispatch, conditional R-type skip, memory stalls
  always_comb begin
    nxt = cur;
    case (cur)
      S_FETCH:  if (!hold) nxt = S_DECODE;
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW:   nxt = S_MEMADR;
          OP_ADD, OP_NDU: nxt = cond_skip(bus.cz, c_flag, z_flag) ? S_FETCH : S_RTEX;
          OP_ADI:         nxt = S_ADIEX;
          OP_BEQ:         nxt = S_BRANCH;
          OP_JMP:         nxt = S_JUMP;
          default:        nxt = S_FETCH;
        endcase
      end
      S_MEMADR: nxt = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (!hold) nxt = S_MEMWB;
      S_MEMWR:  if (!hold) nxt = S_FETCH;
      S_RTEX:   nxt = S_RTWB;
      S_ADIEX:  nxt = S_ADIWB;
      default:  nxt = S_FETCH;
    endcase
  end

  // Flags: ADD/ADI update C and Z, NDU updates Z only, branches leave both
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c_flag <= 1'b0;
      z_flag <= 1'b0;
    end else if (cur == S_RTEX) begin
      z_flag <= bus.zero;
      if (bus.op == OP_ADD) c_flag <= bus.carry;
    end else if (cur == S_ADIEX) begin
      c_flag <= bus.carry;
      z_flag <= bus.zero;
    end
  end

  mc_out_decode u_dec (
    .state     (cur),
    .op        (bus.op),
    .zero      (bus.zero),
`ifdef MC_MEM_WAIT_EN
    .mem_ready (bus.mem_ready),
`endif
    .ctrl      (ctrl)
  );

  // Every strobe is held low while reset is asserted
  assign ctrl_out = reset ? ctrl : '0;

  assign bus.pcen       = ctrl_out.pcen;
  assign bus.memwrite   = ctrl_out.memwrite;
  assign bus.irwrite    = ctrl_out.irwrite;
  assign bus.regwrite   = ctrl_out.regwrite;
  assign bus.alusrca    = ctrl_out.alusrca;
  assign bus.iord       = ctrl_out.iord;
  assign bus.memtoreg   = ctrl_out.memtoreg;
  assign bus.regdst     = ctrl_out.regdst;
  assign bus.alusrcb    = ctrl_out.alusrcb;
  assign bus.pcsrc      = ctrl_out.pcsrc;
  assign bus.alucontrol = ctrl_out.alucontrol;

endmodule

// File: tb/tb_multicycle_controller.sv
// Purpose: directed check of reset, instruction sequencing, flags and control outputs.
// Latency: checks land 1-2 time units after each rising edge.
// Backpressure: drives mem_ready when built with MC_MEM_WAIT_EN.
module tb_multicycle_controller;
  import mc_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  multicycle_controller_if bus_if ();

  multicycle_controller #(.STATE_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic req);
    vectors++;
    assert (obs === req) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, req);
    end
  endtask

  task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] req);
    vectors++;
    assert (obs === req) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, req);
    end
  endtask

  task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] req);
    vectors++;
    assert (obs === req) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, req);
    end
  endtask

  task automatic chkst(input string tag, input state_t obs, input state_t req);
    vectors++;
    assert (obs === req) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, req);
    end
  endtask

  initial begin
    reset        = 1'b0;
    bus_if.op    = OP_LW;
    bus_if.cz    = 2'b00;
    bus_if.zero  = 1'b0;
    bus_if.carry = 1'b0;
`ifdef MC_MEM_WAIT_EN
    bus_if.mem_ready = 1'b1;
`endif
    #12;
    // reset asserted: FETCH, everything quiet, flags clear
    chkst("rst_state", dut.cur, S_FETCH);
    chk1("rst_irwrite", bus_if.irwrite, 1'b0);
    chk1("rst_pcen", bus_if.pcen, 1'b0);
    chk1("rst_c", dut.c_flag, 1'b0);
    chk1("rst_z", dut.z_flag, 1'b0);

    // first FETCH after release
    reset = 1'b1;
    settle();
    chk1("f_irwrite", bus_if.irwrite, 1'b1);
    chk1("f_pcen", bus_if.pcen, 1'b1);
    chk1("f_iord", bus_if.iord, 1'b0);
    chk1("f_alusrca", bus_if.alusrca, 1'b0);
    chk2("f_alusrcb", bus_if.alusrcb, 2'b01);
    chk3("f_aluc", bus_if.alucontrol, 3'b010);
    chk2("f_pcsrc", bus_if.pcsrc, 2'b00);

    // LW: FETCH DECODE MEMADR MEMRD MEMWB
    tick();
    chkst("lw_dec", dut.cur, S_DECODE);
    chk2("lw_dec_srcb", bus_if.alusrcb, 2'b11);
    chk3("lw_dec_aluc", bus_if.alucontrol, 3'b010);
    chk1("lw_dec_regwr", bus_if.regwrite, 1'b0);
    tick();
    chkst("lw_madr", dut.cur, S_MEMADR);
    chk1("lw_madr_srca", bus_if.alusrca, 1'b1);
    chk2("lw_madr_srcb", bus_if.alusrcb, 2'b10);
    chk1("lw_madr_regwr", bus_if.regwrite, 1'b0);
    tick();
    chkst("lw_mrd", dut.cur, S_MEMRD);
    chk1("lw_mrd_iord", bus_if.iord, 1'b1);
    chk1("lw_mrd_regwr", bus_if.regwrite, 1'b0);
    chk1("lw_mrd_m2r", bus_if.memtoreg, 1'b0);
    tick();
    chkst("lw_mwb", dut.cur, S_MEMWB);
    chk1("lw_mwb_regwr", bus_if.regwrite, 1'b1);
    chk1("lw_mwb_m2r", bus_if.memtoreg, 1'b1);
    chk1("lw_mwb_regdst", bus_if.regdst, 1'b0);
    chk1("lw_mwb_memwr", bus_if.memwrite, 1'b0);
    tick();
    chkst("lw_done", dut.cur, S_FETCH);

    // ADD cz=00 with carry=1 zero=0 -> C=1 Z=0
    bus_if.op = OP_ADD;
    bus_if.cz = 2'b00;
    tick();
    tick();
    chkst("add_rtex", dut.cur, S_RTEX);
    chk1("add_srca", bus_if.alusrca, 1'b1);
    chk2("add_srcb", bus_if.alusrcb, 2'b00);
    chk3("add_aluc", bus_if.alucontrol, 3'b010);
    bus_if.carry = 1'b1;
    bus_if.zero  = 1'b0;
    tick();
    chkst("add_rtwb", dut.cur, S_RTWB);
    chk1("add_regwr", bus_if.regwrite, 1'b1);
    chk1("add_regdst", bus_if.regdst, 1'b1);
    chk1("add_m2r", bus_if.memtoreg, 1'b0);
    chk1("add_c", dut.c_flag, 1'b1);
    chk1("add_z", dut.z_flag, 1'b0);
    tick();
    chkst("add_done", dut.cur, S_FETCH);

    // ADD cz=01 with Z=0 -> skipped in 2 cycles, no write
    bus_if.cz = 2'b01;
    tick();
    chkst("skip_dec", dut.cur, S_DECODE);
    chk1("skip_regwr", bus_if.regwrite, 1'b0);
    tick();
    chkst("skip_done", dut.cur, S_FETCH);

    // ADD cz=10 with C=1 -> executes; carry=1 zero=1 -> C=1 Z=1
    bus_if.cz = 2'b10;
    tick();
    tick();
    chkst("addc_rtex", dut.cur, S_RTEX);
    bus_if.carry = 1'b1;
    bus_if.zero  = 1'b1;
    tick();
    chk1("addc_c", dut.c_flag, 1'b1);
    chk1("addc_z", dut.z_flag, 1'b1);
    tick();

    // NDU: nand, updates Z only -> C stays 1, Z=0
    bus_if.op = OP_NDU;
    bus_if.cz = 2'b00;
    tick();
    tick();
    chkst("ndu_rtex", dut.cur, S_RTEX);
    chk3("ndu_aluc", bus_if.alucontrol, 3'b100);
    bus_if.carry = 1'b0;
    bus_if.zero  = 1'b0;
    tick();
    chk1("ndu_c", dut.c_flag, 1'b1);
    chk1("ndu_z", dut.z_flag, 1'b0);
    tick();
    chkst("ndu_done", dut.cur, S_FETCH);

    // ADI: carry=0 zero=1 -> C=0 Z=1
    bus_if.op = OP_ADI;
    tick();
    tick();
    chkst("adi_ex", dut.cur, S_ADIEX);
    chk1("adi_srca", bus_if.alusrca, 1'b1);
    chk2("adi_srcb", bus_if.alusrcb, 2'b10);
    bus_if.carry = 1'b0;
    bus_if.zero  = 1'b1;
    tick();
    chkst("adi_wb", dut.cur, S_ADIWB);
    chk1("adi_regwr", bus_if.regwrite, 1'b1);
    chk1("adi_regdst", bus_if.regdst, 1'b0);
    chk1("adi_c", dut.c_flag, 1'b0);
    chk1("adi_z", dut.z_flag, 1'b1);
    tick();
    chkst("adi_done", dut.cur, S_FETCH);

    // BEQ: pcen follows zero, 3 cycles, flags untouched
    bus_if.op   = OP_BEQ;
    bus_if.zero = 1'b0;
    tick();
    tick();
    chkst("beq_br", dut.cur, S_BRANCH);
    bus_if.zero = 1'b1;
    settle();
    chk1("beq_pcen_t", bus_if.pcen, 1'b1);
    chk2("beq_pcsrc", bus_if.pcsrc, 2'b01);
    chk3("beq_aluc", bus_if.alucontrol, 3'b110);
    bus_if.zero = 1'b0;
    settle();
    chk1("beq_pcen_nt", bus_if.pcen, 1'b0);
    tick();
    chkst("beq_done", dut.cur, S_FETCH);
    chk1("beq_c", dut.c_flag, 1'b0);
    chk1("beq_z", dut.z_flag, 1'b1);

    // illegal opcode: DECODE -> FETCH, no writes
    bus_if.op = 4'b1111;
    tick();
    chk1("ill_regwr", bus_if.regwrite, 1'b0);
    chk1("ill_memwr", bus_if.memwrite, 1'b0);
    tick();
    chkst("ill_done", dut.cur, S_FETCH);

    // JMP
    bus_if.op = OP_JMP;
    tick();
    tick();
    chkst("jmp_st", dut.cur, S_JUMP);
    chk2("jmp_pcsrc", bus_if.pcsrc, 2'b10);
    chk1("jmp_pcen", bus_if.pcen, 1'b1);
    tick();
    chkst("jmp_done", dut.cur, S_FETCH);

    // SW
    bus_if.op = OP_SW;
    tick();
    tick();
    tick();
    chkst("sw_mwr", dut.cur, S_MEMWR);
    chk1("sw_memwr", bus_if.memwrite, 1'b1);
    chk1("sw_iord", bus_if.iord, 1'b1);
    chk1("sw_regwr", bus_if.regwrite, 1'b0);
`ifdef MC_MEM_WAIT_EN
    bus_if.mem_ready = 1'b0;
    settle();
    for (int i = 0; i < 3; i++) begin
      chk1("sw_wait_memwr", bus_if.memwrite, 1'b1);
      tick();
      chkst("sw_wait_st", dut.cur, S_MEMWR);
    end
    bus_if.mem_ready = 1'b1;
    settle();
    chk1("sw_last_memwr", bus_if.memwrite, 1'b1);
`endif
    tick();
    chkst("sw_done", dut.cur, S_FETCH);

    // LW aborted by reset in MEMRD
    bus_if.op = OP_LW;
    tick();
    tick();
    tick();
    chkst("abort_mrd", dut.cur, S_MEMRD);
    reset = 1'b0;
    settle();
    chkst("abort_st", dut.cur, S_FETCH);
    chk1("abort_regwr", bus_if.regwrite, 1'b0);
    chk1("abort_memwr", bus_if.memwrite, 1'b0);
    chk1("abort_c", dut.c_flag, 1'b0);
    chk1("abort_z", dut.z_flag, 1'b0);
    tick();
    chkst("abort_hold", dut.cur, S_FETCH);
    chk1("abort_regwr2", bus_if.regwrite, 1'b0);
    reset = 1'b1;
    settle();
    chk1("rel_irwrite", bus_if.irwrite, 1'b1);
    tick();
    chkst("rel_dec", dut.cur, S_DECODE);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
